// File: rtl/round_timer_pkg.sv
// -----------------------------------------------------------------------------
// round_timer_pkg
// Shared types and constants for the round countdown timer.
//   timerState_t : IDLE / RUN / PAUSED / EXPIRED
//   bcdDigit_t   : one 4-bit BCD digit
//   BCD_MAX/ZERO : digit limits
//   clampBcd()   : saturates a 4-bit value to a legal BCD digit (0..9)
// -----------------------------------------------------------------------------
package round_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } timerState_t;

  typedef logic [3:0] bcdDigit_t;

  localparam bcdDigit_t BCD_MAX  = 4'd9;
  localparam bcdDigit_t BCD_ZERO = 4'd0;

  function automatic bcdDigit_t clampBcd(input bcdDigit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// -----------------------------------------------------------------------------
// bcd_down_digit
// One BCD down-counting digit with synchronous load and borrow chaining.
// Ports:
//   Clock, Reset (async, active-low)
//   load       : load loadValue this edge (wins over decrement)
//   loadValue  : digit to load
//   decEn      : decrement enable for the whole chain
//   borrowIn   : borrow from the less significant digit (tie 1 on the LSD)
//   digit      : registered digit value
//   borrowOut  : digit is 0 and is being decremented (wraps to 9)
// -----------------------------------------------------------------------------
module bcd_down_digit
  import round_timer_pkg::*;
(
  input  logic      Clock,
  input  logic      Reset,
  input  logic      load,
  input  bcdDigit_t loadValue,
  input  logic      decEn,
  input  logic      borrowIn,
  output bcdDigit_t digit,
  output logic      borrowOut
);

  logic decrement;

  assign decrement = decEn && borrowIn;
  assign borrowOut = (digit == BCD_ZERO) && decrement;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      digit <= BCD_ZERO;
    end else if (load) begin
      digit <= loadValue;
    end else if (decrement) begin
      digit <= (digit == BCD_ZERO) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/round_countdown_timer.sv
// -----------------------------------------------------------------------------
// round_countdown_timer
// Counts a game round down from a loaded two-digit BCD value, one step per
// timebase tick, and reports expiry to the game controller.
// Optional feature macro: ROUND_TIMER_WARNING_EN (low-time Warning output).
// Ports:
//   Clock, Reset (async, active-low)
//   OneSecond      : one-cycle tick from the timebase
//   Start          : pulse; load LoadTens/LoadOnes and run
//   Pause          : level; freeze the count while high
//   Abort          : pulse; end the round without expiry
//   LoadTens/Ones  : BCD start time (digits >9 clamp, 00 -> defaults)
//   TimebaseEnable : enable for the timebase, lags RUN by one cycle
//   Tens/Ones      : remaining seconds in BCD
//   Running        : state is RUN
//   TimeUp         : one-cycle pulse after the expiring tick
//   Expired        : state is EXPIRED
//   Warning        : low-time indicator (0 unless the macro is defined)
// -----------------------------------------------------------------------------
module round_countdown_timer
  import round_timer_pkg::*;
#(
  parameter bcdDigit_t DEFAULT_TENS = 4'd3,
  parameter bcdDigit_t DEFAULT_ONES = 4'd0,
  parameter bcdDigit_t WARN_SECONDS = 4'd5
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       OneSecond,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Abort,
  input  logic [3:0] LoadTens,
  input  logic [3:0] LoadOnes,
  output logic       TimebaseEnable,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       Running,
  output logic       TimeUp,
  output logic       Expired,
  output logic       Warning
);

  timerState_t state, stateNext;
  logic        countZero, countOne, decEn, expiring;
  logic        digitLoad, loadIsZero, onesBorrow, tensBorrow;
  bcdDigit_t   tensLoad, onesLoad;

  assign countZero  = (Tens == BCD_ZERO) && (Ones == BCD_ZERO);
  assign countOne   = (Tens == BCD_ZERO) && (Ones == 4'd1);
  // Start and Abort both pre-empt a tick; the zero guard keeps 00 from wrapping.
  assign decEn      = (state == RUN) && OneSecond && !Start && !Abort && !countZero;
  // A tens borrow would mean an underflow, which can never be an expiry.
  assign expiring   = decEn && countOne && !tensBorrow;

  // Abort reuses the load path to clear both digits.
  assign digitLoad  = Start || Abort;
  assign loadIsZero = (LoadTens == 4'd0) && (LoadOnes == 4'd0);
  assign tensLoad   = !Start ? BCD_ZERO : (loadIsZero ? DEFAULT_TENS : clampBcd(LoadTens));
  assign onesLoad   = !Start ? BCD_ZERO : (loadIsZero ? DEFAULT_ONES : clampBcd(LoadOnes));

  bcd_down_digit uOnes (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (digitLoad),
    .loadValue(onesLoad),
    .decEn    (decEn),
    .borrowIn (1'b1),
    .digit    (Ones),
    .borrowOut(onesBorrow)
  );

  bcd_down_digit uTens (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (digitLoad),
    .loadValue(tensLoad),
    .decEn    (decEn),
    .borrowIn (onesBorrow),
    .digit    (Tens),
    .borrowOut(tensBorrow)
  );

  // Priority: Start > Abort > tick/Pause. An expiring tick beats Pause.
  always_comb begin
    stateNext = state;
    if (Start) begin
      stateNext = RUN;
    end else if (Abort) begin
      stateNext = IDLE;
    end else begin
      case (state)
        RUN:     if (expiring) stateNext = EXPIRED;
                 else if (Pause) stateNext = PAUSED;
        PAUSED:  if (!Pause) stateNext = RUN;
        default: stateNext = state;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state          <= IDLE;
      Running        <= 1'b0;
      Expired        <= 1'b0;
      TimeUp         <= 1'b0;
      TimebaseEnable <= 1'b0;
    end else begin
      state          <= stateNext;
      Running        <= (stateNext == RUN);
      Expired        <= (stateNext == EXPIRED);
      TimeUp         <= expiring && !Start && !Abort;
      // Follows the current state, so it drops one cycle after RUN is left.
      TimebaseEnable <= (state == RUN);
    end
  end

`ifdef ROUND_TIMER_WARNING_EN
  // Next digit values mirror the digit chain so Warning updates with the digits.
  bcdDigit_t onesNext, tensNext;
  logic      warnNext;

  always_comb begin
    onesNext = Ones;
    tensNext = Tens;
    if (digitLoad) begin
      onesNext = onesLoad;
      tensNext = tensLoad;
    end else if (decEn) begin
      onesNext = (Ones == BCD_ZERO) ? BCD_MAX : Ones - 4'd1;
      tensNext = (Ones == BCD_ZERO) ? Tens - 4'd1 : Tens;
    end
    warnNext = ((stateNext == RUN) || (stateNext == PAUSED)) &&
               (tensNext == BCD_ZERO) && (onesNext != BCD_ZERO) &&
               (onesNext <= WARN_SECONDS);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) Warning <= 1'b0;
    else        Warning <= warnNext;
  end
`else
  assign Warning = 1'b0;
`endif

endmodule
